xor_stream_cipher: RTL and testbench

XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

---
 rtl/xor_stream_cipher.sv | 96 +++++++++
 tb/tb_xor_stream_cipher.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_cipher.sv
// Byte-wide XOR stream cipher with a one-deep output register; rekeys from an external key generator
// every ROT_PERIOD accepted bytes (LOAD -> RUN -> REKEY -> WAIT -> LOAD).
module xor_stream_cipher #(
  parameter int unsigned ROT_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  output logic       key_req,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] key_epoch
);

  typedef enum logic [1:0] {LOAD, RUN, REKEY, WAIT} state_t;

  localparam logic [7:0] LAST_IDX = 8'(ROT_PERIOD - 1);

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [3:0] epoch_q, epoch_d;
  logic       accept;

  assign in_ready  = (state_q == RUN) && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign key_epoch = epoch_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    epoch_d = epoch_q;
    data_d  = data_q;
    valid_d = valid_q;
    key_req = 1'b0;

    case (state_q)
      LOAD: begin
        key_d   = key_in;
        cnt_d   = 8'd0;
        state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) state_d = REKEY;
        end
      end
      REKEY: begin
        key_req = !rst;
        epoch_d = epoch_q + 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase

    // Output register drains independently of the FSM, so a pending byte survives a rekey.
    if (accept) begin
      data_d  = in_data ^ key_q;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      key_q   <= 8'd0;
      cnt_q   <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      epoch_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      epoch_q <= epoch_d;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench: an encrypting and a decrypting instance (ROT_PERIOD=4), each with its own key generator model.
module tb_xor_stream_cipher;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [7:0] key_in, in_data, out_data;
  logic       key_req, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] key_epoch;

  logic [7:0] d_key_in, d_in_data, d_out_data;
  logic       d_key_req, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [3:0] d_key_epoch;

  int unsigned kidx, kidx2;
  int checks = 0;
  int errors = 0;
  logic [7:0] ct [64];

  always #5 clk = ~clk;

  function automatic logic [7:0] key_fn(input int unsigned i);
    return 8'(32'hA5 + i * 32'd29);
  endfunction

  function automatic logic [7:0] pt_fn(input int n);
    return 8'(n * 7 + 3);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) kidx <= 0;
    else if (key_req) kidx <= kidx + 1;
  end
  always_ff @(posedge clk) begin
    if (rst2) kidx2 <= 0;
    else if (d_key_req) kidx2 <= kidx2 + 1;
  end
  assign key_in   = key_fn(kidx);
  assign d_key_in = key_fn(kidx2);

  xor_stream_cipher #(.ROT_PERIOD(4)) u_enc (
    .clk(clk), .rst(rst), .key_in(key_in), .key_req(key_req),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .key_epoch(key_epoch)
  );

  xor_stream_cipher #(.ROT_PERIOD(4)) u_dec (
    .clk(clk), .rst(rst2), .key_in(d_key_in), .key_req(d_key_req),
    .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .key_epoch(d_key_epoch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic send4(input logic [7:0] base);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_data = base + 8'(b);
      tick;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    logic acc;
    rst = 1'b1; rst2 = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_data = 8'h00; d_out_ready = 1'b1;
    tick; tick;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_key_req", {31'd0, key_req}, 32'd0);
    chk("rst_epoch", {28'd0, key_epoch}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("load_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("run_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic transform: 3C ^ A5 = 99
    in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_data", {24'd0, out_data}, 32'h99);
    tick;
    chk("basic_drain", {31'd0, out_valid}, 32'd0);

    // Rekey after 4 back-to-back bytes
    do_reset;
    in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_data = 8'h11 * 8'(b + 1);
      #1;
      chk("rk_in_ready", {31'd0, in_ready}, 32'd1);
      tick;
      chk("rk_data", {24'd0, out_data}, {24'd0, (8'h11 * 8'(b + 1)) ^ 8'hA5});
    end
    in_data = 8'h55;
    chk("rk_req_pulse", {31'd0, key_req}, 32'd1);
    chk("rk_stall_rekey", {31'd0, in_ready}, 32'd0);
    chk("rk_epoch_pre", {28'd0, key_epoch}, 32'd0);
    tick;
    chk("rk_req_wait", {31'd0, key_req}, 32'd0);
    chk("rk_epoch", {28'd0, key_epoch}, 32'd1);
    chk("rk_stall_wait", {31'd0, in_ready}, 32'd0);
    chk("rk_drained", {31'd0, out_valid}, 32'd0);
    tick;
    chk("rk_stall_load", {31'd0, in_ready}, 32'd0);
    chk("rk_req_load", {31'd0, key_req}, 32'd0);
    tick;
    chk("rk_ready_again", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("rk_newkey_data", {24'd0, out_data}, 32'h97);
    chk("rk_newkey_valid", {31'd0, out_valid}, 32'd1);

    // Backpressure
    do_reset;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    tick;
    chk("bp_first_data", {24'd0, out_data}, 32'h99);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_data = 8'h5A;
    tick;
    chk("bp_hold_data", {24'd0, out_data}, 32'h99);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("bp_second_data", {24'd0, out_data}, 32'hFF);
    chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);
    tick;
    chk("bp_final_drain", {31'd0, out_valid}, 32'd0);

    // Reset in WAIT with a pending output
    do_reset;
    send4(8'h20);
    out_ready = 1'b0;
    tick;
    chk("rw_wait_valid", {31'd0, out_valid}, 32'd1);
    chk("rw_wait_epoch", {28'd0, key_epoch}, 32'd1);
    rst = 1'b1;
    tick;
    chk("rw_valid", {31'd0, out_valid}, 32'd0);
    chk("rw_key_req", {31'd0, key_req}, 32'd0);
    chk("rw_epoch", {28'd0, key_epoch}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rw_load_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("rw_run_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Reset asserted during REKEY suppresses key_req
    do_reset;
    send4(8'h40);
    rst = 1'b1;
    #1;
    chk("rr_key_req_masked", {31'd0, key_req}, 32'd0);
    tick;
    chk("rr_epoch", {28'd0, key_epoch}, 32'd0);
    rst = 1'b0;
    tick;

    // 16 epochs of encryption, epoch wrap
    do_reset;
    n = 0; cyc = 0; in_valid = 1'b1;
    while (n < 64 && cyc < 1000) begin
      in_data = pt_fn(n);
      #1;
      acc = in_ready;
      tick;
      cyc++;
      if (acc) begin
        ct[n] = out_data;
        chk("enc_data", {24'd0, out_data}, {24'd0, pt_fn(n) ^ key_fn(n / 4)});
        chk("enc_epoch", {28'd0, key_epoch}, 32'((n / 4) % 16));
        n++;
      end
    end
    in_valid = 1'b0;
    chk("enc_count", 32'(n), 32'd64);
    tick; tick;
    chk("enc_epoch_wrap", {28'd0, key_epoch}, 32'd0);

    // Round trip through the second instance
    rst2 = 1'b0;
    tick;
    n = 0; cyc = 0; d_in_valid = 1'b1;
    while (n < 64 && cyc < 1000) begin
      d_in_data = ct[n];
      #1;
      acc = d_in_ready;
      tick;
      cyc++;
      if (acc) begin
        chk("dec_plain", {24'd0, d_out_data}, {24'd0, pt_fn(n)});
        n++;
      end
    end
    d_in_valid = 1'b0;
    chk("dec_count", 32'(n), 32'd64);
    tick; tick;
    chk("dec_epoch_wrap", {28'd0, d_key_epoch}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
